// File: rtl/fp_align_sequencer.sv
// Exponent-alignment sequencer for the FP adder front end: shifts the smaller-exponent
// mantissa right one bit per cycle until exponents match, collecting guard/round/sticky.
module fp_align_sequencer #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 24,
  parameter int unsigned MAX_SH = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [MAN_W-1:0] man_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] man_big,
  output logic [MAN_W-1:0] man_small,
  output logic             guard,
  output logic             round,
  output logic             sticky,
  output logic             swapped,
  output logic             inc_en,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(MAX_SH + 1);

  typedef enum logic [1:0] {StIdle, StCmp, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic             init_q;
  logic [EXP_W-1:0] big_exp_q, big_exp_d;
  logic [EXP_W-1:0] small_exp_q, small_exp_d;
  logic [MAN_W-1:0] man_big_q, man_big_d;
  logic [MAN_W-1:0] man_small_q, man_small_d;
  logic             guard_q, guard_d;
  logic             round_q, round_d;
  logic             sticky_q, sticky_d;
  logic             swapped_q, swapped_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [EXP_W-1:0] inc_sum;

  // Controlled incrementor: adds the enable bit to the small exponent.
  assign inc_sum = small_exp_q + {{(EXP_W-1){1'b0}}, inc_en};

  always_comb begin
    state_d     = state_q;
    big_exp_d   = big_exp_q;
    small_exp_d = small_exp_q;
    man_big_d   = man_big_q;
    man_small_d = man_small_q;
    guard_d     = guard_q;
    round_d     = round_q;
    sticky_d    = sticky_q;
    swapped_d   = swapped_q;
    count_d     = count_q;
    in_ready    = 1'b0;
    inc_en      = 1'b0;
    out_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = init_q;
        if (in_valid && init_q) begin
          // Operand A parks in the big slot, B in the small slot; CMP swaps if needed.
          big_exp_d   = exp_a;
          man_big_d   = man_a;
          small_exp_d = exp_b;
          man_small_d = man_b;
          state_d     = StCmp;
        end
      end
      StCmp: begin
        if (big_exp_q < small_exp_q) begin
          big_exp_d   = small_exp_q;
          man_big_d   = man_small_q;
          small_exp_d = big_exp_q;
          man_small_d = man_big_q;
          swapped_d   = 1'b1;
        end else begin
          swapped_d   = 1'b0;
        end
        count_d  = '0;
        guard_d  = 1'b0;
        round_d  = 1'b0;
        sticky_d = 1'b0;
        state_d  = (big_exp_q == small_exp_q) ? StDone : StShift;
      end
      StShift: begin
        inc_en      = 1'b1;
        small_exp_d = inc_sum;
        {man_small_d, guard_d, round_d} = {man_small_q, guard_q, round_q} >> 1;
        sticky_d    = sticky_q | round_q;
        count_d     = count_q + CntW'(1);
        if (inc_sum == big_exp_q) begin
          state_d = StDone;
        end else if (count_q == CntW'(MAX_SH - 1)) begin
          state_d     = StDone;
          small_exp_d = big_exp_q;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      init_q      <= 1'b0;
      big_exp_q   <= '0;
      small_exp_q <= '0;
      man_big_q   <= '0;
      man_small_q <= '0;
      guard_q     <= 1'b0;
      round_q     <= 1'b0;
      sticky_q    <= 1'b0;
      swapped_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      big_exp_q   <= big_exp_d;
      small_exp_q <= small_exp_d;
      man_big_q   <= man_big_d;
      man_small_q <= man_small_d;
      guard_q     <= guard_d;
      round_q     <= round_d;
      sticky_q    <= sticky_d;
      swapped_q   <= swapped_d;
      count_q     <= count_d;
    end
  end

  assign exp_out   = big_exp_q;
  assign man_big   = man_big_q;
  assign man_small = man_small_q;
  assign guard     = guard_q;
  assign round     = round_q;
  assign sticky    = sticky_q;
  assign swapped   = swapped_q;
  assign busy      = (state_q != StIdle);

endmodule
